// File: rtl/receive.sv
// 1000BASE-X PCS receive state machine.
// Turns decoded 8B/10B code-groups into GMII receive signals. It recognises
// the ordered sets /I/, /S/, /T/ and /R/, flags false carrier, data errors and
// early packet end, and keeps saturating packet and error counters.
//
// Ports:
//   GTX_CLK        clock, rising edge
//   mr_main_reset  synchronous reset, active-high
//   sync_status    1 = decoder has code-group sync
//   RX_CODE_GROUP  decoded octet, valid every cycle
//   RX_IS_K        1 = RX_CODE_GROUP is a control character
//   RXD            GMII receive data (registered)
//   RX_DV          GMII receive data valid (registered)
//   RX_ER          GMII receive error (registered)
//   receiving      packet reception in progress (registered)
//   pkt_count      packets ended by /T/, saturating
//   err_count      cycles with RX_ER set, saturating
module receive #(
    parameter int unsigned CNT_W = 16,
    parameter logic [7:0]  K28_5 = 8'hBC,
    parameter logic [7:0]  K27_7 = 8'hFB,
    parameter logic [7:0]  K29_7 = 8'hFD,
    parameter logic [7:0]  K23_7 = 8'hF7,
    parameter logic [7:0]  D5_6  = 8'hC5,
    parameter logic [7:0]  D16_2 = 8'h50
) (
    input  logic             GTX_CLK,
    input  logic             mr_main_reset,
    input  logic             sync_status,
    input  logic [7:0]       RX_CODE_GROUP,
    input  logic             RX_IS_K,
    output logic [7:0]       RXD,
    output logic             RX_DV,
    output logic             RX_ER,
    output logic             receiving,
    output logic [CNT_W-1:0] pkt_count,
    output logic [CNT_W-1:0] err_count
);

    localparam logic [7:0] PREAMBLE   = 8'h55;
    localparam logic [7:0] FALSE_CARR = 8'h0E;

    typedef enum logic [5:0] {
        LINK_FAILED = 6'b000001,
        WAIT_FOR_K  = 6'b000010,
        RX_K        = 6'b000100,
        IDLE_D      = 6'b001000,
        RECEIVE     = 6'b010000,
        TRI_WAIT    = 6'b100000
    } state_e;

    state_e           state_q, state_d;
    logic [7:0]       rxd_q, rxd_d;
    logic             rx_dv_q, rx_dv_d;
    logic             rx_er_q, rx_er_d;
    logic             receiving_q, receiving_d;
    logic [CNT_W-1:0] pkt_count_q, pkt_count_d;
    logic [CNT_W-1:0] err_count_q, err_count_d;
    logic             pkt_done;

    logic is_comma, is_sop, is_eop, is_ext, is_idle_d;

    // Code-group classification
    always_comb begin
        is_comma  = RX_IS_K && (RX_CODE_GROUP == K28_5);
        is_sop    = RX_IS_K && (RX_CODE_GROUP == K27_7);
        is_eop    = RX_IS_K && (RX_CODE_GROUP == K29_7);
        is_ext    = RX_IS_K && (RX_CODE_GROUP == K23_7);
        is_idle_d = !RX_IS_K && ((RX_CODE_GROUP == D5_6) || (RX_CODE_GROUP == D16_2));
    end

    // Next state, next outputs and counter updates
    always_comb begin
        state_d     = state_q;
        rxd_d       = 8'h00;
        rx_dv_d     = 1'b0;
        rx_er_d     = 1'b0;
        receiving_d = 1'b0;
        pkt_done    = 1'b0;

        if (!sync_status) begin
            state_d = LINK_FAILED;
            // Losing sync mid-packet must corrupt the frame on GMII
            if (receiving_q) begin
                rx_dv_d = 1'b1;
                rx_er_d = 1'b1;
            end
        end else begin
            case (state_q)
                LINK_FAILED: state_d = WAIT_FOR_K;
                WAIT_FOR_K:  if (is_comma) state_d = RX_K;
                RX_K:        state_d = is_idle_d ? IDLE_D : WAIT_FOR_K;
                IDLE_D: begin
                    if (is_comma) begin
                        state_d = RX_K;
                    end else if (is_sop) begin
                        state_d     = RECEIVE;
                        rxd_d       = PREAMBLE;
                        rx_dv_d     = 1'b1;
                        receiving_d = 1'b1;
                    end else begin
                        state_d = WAIT_FOR_K;
                        rxd_d   = FALSE_CARR;
                        rx_er_d = 1'b1;
                    end
                end
                RECEIVE: begin
                    if (!RX_IS_K) begin
                        rxd_d       = RX_CODE_GROUP;
                        rx_dv_d     = 1'b1;
                        receiving_d = 1'b1;
                    end else if (is_eop) begin
                        state_d  = TRI_WAIT;
                        pkt_done = 1'b1;
                    end else if (is_comma) begin
                        // Early end: idle arrived without /T/
                        state_d = RX_K;
                        rx_dv_d = 1'b1;
                        rx_er_d = 1'b1;
                    end else begin
                        rxd_d       = RX_CODE_GROUP;
                        rx_dv_d     = 1'b1;
                        rx_er_d     = 1'b1;
                        receiving_d = 1'b1;
                    end
                end
                TRI_WAIT: begin
                    // A missing /R/ before the next /I/ is tolerated
                    if (is_comma && !is_ext) state_d = RX_K;
                    else                     state_d = WAIT_FOR_K;
                end
                default: state_d = LINK_FAILED;
            endcase
        end

        pkt_count_d = pkt_count_q;
        err_count_d = err_count_q;
        if (pkt_done && (pkt_count_q != {CNT_W{1'b1}}))
            pkt_count_d = pkt_count_q + CNT_W'(1);
        if (rx_er_d && (err_count_q != {CNT_W{1'b1}}))
            err_count_d = err_count_q + CNT_W'(1);
    end

    // State and output registers
    always_ff @(posedge GTX_CLK) begin
        if (mr_main_reset) begin
            state_q     <= LINK_FAILED;
            rxd_q       <= 8'h00;
            rx_dv_q     <= 1'b0;
            rx_er_q     <= 1'b0;
            receiving_q <= 1'b0;
            pkt_count_q <= '0;
            err_count_q <= '0;
        end else begin
            state_q     <= state_d;
            rxd_q       <= rxd_d;
            rx_dv_q     <= rx_dv_d;
            rx_er_q     <= rx_er_d;
            receiving_q <= receiving_d;
            pkt_count_q <= pkt_count_d;
            err_count_q <= err_count_d;
        end
    end

    assign RXD       = rxd_q;
    assign RX_DV     = rx_dv_q;
    assign RX_ER     = rx_er_q;
    assign receiving = receiving_q;
    assign pkt_count = pkt_count_q;
    assign err_count = err_count_q;

endmodule

// File: tb/tb_receive.sv
// Testbench for receive: directed code-group sequences with hand-computed
// GMII responses queued per cycle; a monitor compares each registered
// response one cycle later. A second instance with 2-bit counters shares
// the stimulus to exercise counter saturation.
module tb_receive;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       sync = 1'b0;
    logic       is_k = 1'b0;
    logic [7:0] cg = 8'h00;

    logic [7:0]  rxd, rxd2;
    logic        dv, er, recv, dv2, er2, recv2;
    logic [15:0] pkt, err;
    logic [1:0]  pkt2, err2;

    always #5 clk = ~clk;

    receive #(.CNT_W(16)) dut (
        .GTX_CLK(clk), .mr_main_reset(rst), .sync_status(sync),
        .RX_CODE_GROUP(cg), .RX_IS_K(is_k),
        .RXD(rxd), .RX_DV(dv), .RX_ER(er), .receiving(recv),
        .pkt_count(pkt), .err_count(err)
    );

    receive #(.CNT_W(2)) dut_small (
        .GTX_CLK(clk), .mr_main_reset(rst), .sync_status(sync),
        .RX_CODE_GROUP(cg), .RX_IS_K(is_k),
        .RXD(rxd2), .RX_DV(dv2), .RX_ER(er2), .receiving(recv2),
        .pkt_count(pkt2), .err_count(err2)
    );

    typedef struct {
        string       nm;
        logic [10:0] outs;   // {rxd, dv, er, receiving}
        logic [15:0] pkt;
        logic [15:0] err;
        logic [1:0]  pkt_s;
        logic [1:0]  err_s;
    } exp_t;

    exp_t sb[$];
    exp_t e;
    int   n_checks = 0;
    int   n_pass   = 0;
    int   m_pkt    = 0;
    int   m_err    = 0;

    function automatic logic [1:0] sat2(input int v);
        return (v > 3) ? 2'd3 : 2'(v);
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", nm, act, exp);
    endtask

    // Monitor: one expected record per clock edge
    always @(posedge clk) begin
        #1;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            chk({e.nm, " outputs"}, 32'({rxd, dv, er, recv}), 32'(e.outs));
            chk({e.nm, " pkt_count"}, 32'(pkt), 32'(e.pkt));
            chk({e.nm, " err_count"}, 32'(err), 32'(e.err));
            chk({e.nm, " small outputs"}, 32'({rxd2, dv2, er2, recv2}), 32'(e.outs));
            chk({e.nm, " small counters"}, 32'({pkt2, err2}), 32'({e.pkt_s, e.err_s}));
        end
    end

    // Apply one code-group and queue the response expected after the next edge
    task automatic drv(input string nm, input bit r, input bit s, input bit k,
                       input logic [7:0] c, input logic [7:0] xrxd, input bit xdv,
                       input bit xer, input bit xrecv, input bit xpkt);
        exp_t x;
        @(negedge clk);
        rst = r; sync = s; is_k = k; cg = c;
        if (r) begin
            m_pkt = 0; m_err = 0;
        end else begin
            if (xpkt) m_pkt++;
            if (xer)  m_err++;
        end
        x.nm = nm; x.outs = {xrxd, xdv, xer, xrecv};
        x.pkt = 16'(m_pkt); x.err = 16'(m_err);
        x.pkt_s = sat2(m_pkt); x.err_s = sat2(m_err);
        sb.push_back(x);
    endtask

    task automatic idle(input string nm);
        drv(nm, 0, 1, 1, 8'hBC, 8'h00, 0, 0, 0, 0);
        drv(nm, 0, 1, 0, 8'h50, 8'h00, 0, 0, 0, 0);
    endtask

    task automatic dat(input string nm, input logic [7:0] c);
        drv(nm, 0, 1, 0, c, c, 1, 0, 1, 0);
    endtask

    task automatic sop(input string nm);
        drv(nm, 0, 1, 1, 8'hFB, 8'h55, 1, 0, 1, 0);
    endtask

    task automatic eop(input string nm);
        drv(nm, 0, 1, 1, 8'hFD, 8'h00, 0, 0, 0, 1);
    endtask

    initial begin
        // 1: reset, then idle stream
        repeat (3) drv("reset", 1, 0, 0, 8'h00, 8'h00, 0, 0, 0, 0);
        drv("sync_up", 0, 1, 0, 8'h00, 8'h00, 0, 0, 0, 0);
        repeat (3) idle("idle");

        // 2: clean packet with /T/ /R/
        sop("pkt_sop");
        repeat (6) dat("pkt_pre", 8'h55);
        dat("pkt_d5", 8'hD5);
        dat("pkt_a1", 8'hA1);
        dat("pkt_b2", 8'hB2);
        eop("pkt_eop");
        drv("pkt_ext", 0, 1, 1, 8'hF7, 8'h00, 0, 0, 0, 0);
        idle("pkt_idle");

        // 3: data error mid-packet, then /T/ followed directly by /I/
        sop("derr_sop");
        dat("derr_55", 8'h55);
        dat("derr_a1", 8'hA1);
        drv("derr_k1c", 0, 1, 1, 8'h1C, 8'h1C, 1, 1, 1, 0);
        dat("derr_b2", 8'hB2);
        eop("derr_eop");
        idle("derr_idle");

        // 4: early end with /I/ instead of /T/
        sop("early_sop");
        dat("early_55", 8'h55);
        dat("early_a1", 8'hA1);
        drv("early_kbc", 0, 1, 1, 8'hBC, 8'h00, 1, 1, 0, 0);
        drv("early_d50", 0, 1, 0, 8'h50, 8'h00, 0, 0, 0, 0);

        // 5a: sync loss mid-packet
        sop("sync_sop");
        dat("sync_55", 8'h55);
        drv("sync_drop", 0, 0, 0, 8'hA1, 8'h00, 1, 1, 0, 0);
        drv("sync_low", 0, 0, 0, 8'hA2, 8'h00, 0, 0, 0, 0);
        drv("sync_back", 0, 1, 0, 8'hA3, 8'h00, 0, 0, 0, 0);
        drv("sync_wait", 0, 1, 0, 8'h55, 8'h00, 0, 0, 0, 0);
        drv("sync_wait_sop", 0, 1, 1, 8'hFB, 8'h00, 0, 0, 0, 0);
        idle("sync_idle");
        // sync loss outside a packet gives no error
        drv("sync_drop_idle", 0, 0, 1, 8'hBC, 8'h00, 0, 0, 0, 0);
        drv("sync_back2", 0, 1, 0, 8'h00, 8'h00, 0, 0, 0, 0);
        idle("sync_idle2");

        // 5b: reset mid-packet
        sop("rst_sop");
        dat("rst_55", 8'h55);
        drv("rst_mid", 1, 1, 0, 8'hA1, 8'h00, 0, 0, 0, 0);
        drv("rst_rel", 0, 1, 0, 8'hA2, 8'h00, 0, 0, 0, 0);
        idle("rst_idle");

        // 6: false carrier, repeated to saturate the 2-bit counter
        for (int i = 0; i < 4; i++) begin
            drv("fc_d33", 0, 1, 0, 8'h33, 8'h0E, 0, 1, 0, 0);
            idle("fc_idle");
        end
        drv("fc_kf7", 0, 1, 1, 8'hF7, 8'h0E, 0, 1, 0, 0);
        idle("fc_idle");
        drv("fc_rxk_bad", 0, 1, 1, 8'hBC, 8'h00, 0, 0, 0, 0);
        drv("fc_rxk_bad2", 0, 1, 0, 8'h33, 8'h00, 0, 0, 0, 0);
        idle("fc_idle3");

        // Second packet after saturation of error counter
        sop("p2_sop");
        dat("p2_ab", 8'hAB);
        eop("p2_eop");
        idle("p2_idle");

        repeat (5) @(posedge clk);
        #2;
        n_checks++;
        if (sb.size() == 0) n_pass++;
        else $display("FAIL drain: %0d records left, expected 0", sb.size());

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/receive.md
Name: receive

Overview:
- 1000BASE-X PCS receive-side state machine. It is the counterpart of the transmit block.
- Sits between the 8B/10B decoder and the GMII receive interface.
- Consumes one decoded code-group per GTX_CLK and recognises ordered sets /I/, /S/, /T/, /R/.
- Regenerates GMII RXD/RX_DV/RX_ER, flags errors, and keeps saturating packet and error counters.

Parameters:
- CNT_W, 16, width of pkt_count and err_count.
- K28_5, 8'hBC, comma code (first octet of /I/).
- K27_7, 8'hFB, /S/ start of packet.
- K29_7, 8'hFD, /T/ end of packet.
- K23_7, 8'hF7, /R/ carrier extend.
- D5_6, 8'hC5, second octet of /I1/.
- D16_2, 8'h50, second octet of /I2/.

Ports:
- GTX_CLK  in  1  clock; all logic on rising edge.
- mr_main_reset  in  1  synchronous reset, active-high.
- sync_status  in  1  1 = decoder has code-group sync.
- RX_CODE_GROUP  in  8  decoded octet, valid every cycle.
- RX_IS_K  in  1  1 = RX_CODE_GROUP is a K (control) character.
- RXD  out  8  GMII receive data.
- RX_DV  out  1  GMII receive data valid.
- RX_ER  out  1  GMII receive error.
- receiving  out  1  packet reception in progress.
- pkt_count  out  CNT_W  packets completed with /T/, saturating.
- err_count  out  CNT_W  RX_ER assertions, saturating.

Behaviour:
- Single clock GTX_CLK; mr_main_reset is synchronous and active-high.
- Reset: state=LINK_FAILED; RXD=0, RX_DV=0, RX_ER=0, receiving=0, counters=0.
- Reset mid-packet drops all outputs to 0 on the next edge with no RX_ER pulse.
- Priority: reset > sync_status=0 > code-group decode.
- Outputs are registered. The code-group present before edge n is reflected on RXD/RX_DV/RX_ER after edge n (latency 1).
- RXD=0 whenever RX_DV=0 and RX_ER=0.
- Code-group notation:
  - K(x) = RX_IS_K=1 and RX_CODE_GROUP=x.
  - D(x) = RX_IS_K=0 and RX_CODE_GROUP=x.
- State encoding: one-hot, 6 states.
- LINK_FAILED:
  - RX_DV=0, RX_ER=0.
  - Go to WAIT_FOR_K when sync_status=1.
- WAIT_FOR_K:
  - K(K28_5) -> RX_K.
  - Anything else: stay.
- RX_K:
  - D(D5_6) or D(D16_2) -> IDLE_D.
  - Anything else -> WAIT_FOR_K.
- IDLE_D:
  - K(K28_5) -> RX_K.
  - K(K27_7) -> RECEIVE; RXD=8'h55, RX_DV=1, receiving=1.
  - Anything else is false carrier: RXD=8'h0E, RX_ER=1, RX_DV=0, -> WAIT_FOR_K.
- RECEIVE (each cycle):
  - Any D: RXD=code, RX_DV=1, RX_ER=0, stay.
  - K(K29_7): RX_DV=0, receiving=0, pkt_count+1, -> TRI_WAIT.
  - K(K28_5), early end: RX_DV=1, RX_ER=1, RXD=0 for one cycle, receiving=0, -> RX_K.
  - Any other K, data error: RXD=code, RX_DV=1, RX_ER=1, stay.
- TRI_WAIT:
  - K(K23_7) -> WAIT_FOR_K.
  - K(K28_5) -> RX_K (missing /R/ tolerated, no error).
  - Anything else -> WAIT_FOR_K.
  - Outputs 0 throughout.
- sync_status=0 in any state -> LINK_FAILED next edge.
  - If receiving=1 at that time: one cycle of RX_DV=1, RX_ER=1, RXD=0, receiving=0.
  - Otherwise outputs 0.
- err_count increments on every cycle RX_ER is set to 1.
- Both counters saturate at all-ones and never wrap.
- Simultaneous end-of-packet and error in one code-group is impossible: each code-group is classified once.

Test Plan:
1. Reset high 3 cycles, then sync_status=1 with repeated K(BC),D(50) -> RX_DV=0, RX_ER=0, RXD=0, counters 0 throughout.
2. Idle, then K(FB), D(55)x6, D(D5), D(A1), D(B2), K(FD), K(F7), idle -> one cycle after /S/:
   - RX_DV=1 for 10 cycles with RXD=55,55,55,55,55,55,55,D5,A1,B2.
   - Then RX_DV=0.
   - pkt_count=1, err_count=0.
3. Mid-packet K(1C) between D(A1) and D(B2) -> one cycle RX_DV=1, RX_ER=1, RXD=1C; reception continues; err_count=1.
4. Mid-packet K(BC) instead of /T/ -> one cycle RX_DV=1, RX_ER=1, then RX_DV=0; pkt_count unchanged.
5. sync_status=0 mid-packet -> one cycle RX_ER=1, then all outputs 0 until sync returns and /I/ is seen. Separately, reset mid-packet -> outputs 0 next edge, RX_ER never asserted.
6. In IDLE_D feed D(33) -> RXD=0E, RX_ER=1, RX_DV=0 for one cycle; err_count+1. With CNT_W=2, after 5 errors err_count holds at 3.
